// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory line responder.
// Line geometry, latency counter width, FSM states, captured request payload.
package dmem_pkg;

    localparam int LINE_BITS      = 128;
    localparam int WORD_BITS      = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_BITS    = 4;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    typedef struct packed {
        logic                      we;
        logic [WORDS_PER_LINE-1:0] wmask;
        logic [LINE_BITS-1:0]      wdata;
    } req_t;

endpackage

// File: rtl/dmem_line_array.sv
// Line storage: 2**LINE_AW lines split into four independent 32-bit lanes.
// Ports: clk; wr_en/wmask/wdata masked write; rd_en registered read; idx line index; rdata read line.
module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int LINE_AW = 10
) (
    input  logic                      clk,
    input  logic [LINE_AW-1:0]        idx,
    input  logic                      wr_en,
    input  logic [WORDS_PER_LINE-1:0] wmask,
    input  logic [LINE_BITS-1:0]      wdata,
    input  logic                      rd_en,
    output logic [LINE_BITS-1:0]      rdata
);

    localparam int DEPTH = 1 << LINE_AW;

    for (genvar w = 0; w < WORDS_PER_LINE; w++) begin : g_lane
        logic [WORD_BITS-1:0] lane [DEPTH];
        logic [WORD_BITS-1:0] q;

        // Each lane owns its write enable so masked-off words keep their value.
        always_ff @(posedge clk) begin
            if (wr_en && wmask[w]) begin
                lane[idx] <= wdata[w*WORD_BITS +: WORD_BITS];
            end
            if (rd_en) begin
                q <= lane[idx];
            end
        end

        assign rdata[w*WORD_BITS +: WORD_BITS] = q;
    end

endmodule

// File: rtl/dmem_line_server.sv
// Main-memory responder for cache refills and write-backs with fixed latency.
// Ports: clk, rst (async high); req/we/addr/wmask/wdata request; ready, done pulse, rdata line.
module dmem_line_server
    import dmem_pkg::*;
#(
    parameter int LINE_AW = 10,
    parameter int LATENCY = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic                      we,
    input  logic [31:0]               addr,
    input  logic [WORDS_PER_LINE-1:0] wmask,
    input  logic [LINE_BITS-1:0]      wdata,
    output logic                      ready,
    output logic                      done,
    output logic [LINE_BITS-1:0]      rdata
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [LINE_AW-1:0]   idx_q;
    req_t                 cap_q;
    logic                 accept;
    logic                 commit;
    logic                 rd_valid_q;
    logic [LINE_BITS-1:0] arr_rdata;

    // Offset and alias bits of the address are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^{addr[31:LINE_AW+OFFSET_BITS],
                           addr[OFFSET_BITS-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req) state_d = BUSY;
            BUSY: if (cnt_q == '0) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready  = 1'b0;
        done   = 1'b0;
        commit = 1'b0;
        unique case (1'b1)
            (state_q == IDLE): ready  = 1'b1;
            (state_q == BUSY): commit = (cnt_q == '0);
            (state_q == RESP): done   = 1'b1;
            default: ;
        endcase
    end

    assign accept = req & ready;

    // Request is frozen at acceptance; later bus activity cannot reach storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
            cap_q <= '0;
        end else if (accept) begin
            cnt_q       <= CNT_LOAD;
            idx_q       <= addr[LINE_AW+OFFSET_BITS-1:OFFSET_BITS];
            cap_q.we    <= we;
            cap_q.wmask <= wmask;
            cap_q.wdata <= wdata;
        end else if (state_q == BUSY && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage has no reset, so rdata reads as zero until a read lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
        end else if (commit && !cap_q.we) begin
            rd_valid_q <= 1'b1;
        end
    end

    dmem_line_array #(
        .LINE_AW (LINE_AW)
    ) u_array (
        .clk   (clk),
        .idx   (idx_q),
        .wr_en (commit & cap_q.we),
        .wmask (cap_q.wmask),
        .wdata (cap_q.wdata),
        .rd_en (commit & ~cap_q.we),
        .rdata (arr_rdata)
    );

    assign rdata = rd_valid_q ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_line_server.sv
// Directed testbench for dmem_line_server.
// Table-driven accesses plus hand-written reset and busy-request sequences.
module tb_dmem_line_server;

    localparam int LINE_AW = 10;
    localparam int LATENCY = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req = 1'b0;
    logic         we = 1'b0;
    logic [31:0]  addr = '0;
    logic [3:0]   wmask = '0;
    logic [127:0] wdata = '0;
    logic         ready;
    logic         done;
    logic [127:0] rdata;

    int n_pass = 0;
    int n_total = 0;

    logic [127:0] last_rd = '0;

    always #5 clk = ~clk;

    dmem_line_server #(
        .LINE_AW (LINE_AW),
        .LATENCY (LATENCY)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wmask (wmask),
        .wdata (wdata),
        .ready (ready),
        .done  (done),
        .rdata (rdata)
    );

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [3:0]   wmask;
        logic [127:0] wdata;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic access(input logic w, input logic [31:0] a,
                          input logic [3:0] m, input logic [127:0] d,
                          output logic [127:0] rd);
        int  k;
        bit  seen;
        bit  rdy_bad;
        @(negedge clk);
        chk("ready_before_req", ready, 1);
        req = 1'b1; we = w; addr = a; wmask = m; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; we = ~w; addr = ~a; wmask = ~m; wdata = ~d;
        k = 0; seen = 0; rdy_bad = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (done) seen = 1;
            else if (ready) rdy_bad = 1;
        end
        chk("done_seen", seen, 1);
        chk("latency_edges", k, LATENCY + 1);
        chk("ready_low_busy", rdy_bad, 0);
        chk("ready_low_resp", ready, 0);
        rd = rdata;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("ready_after_done", ready, 1);
    endtask

    initial begin
        logic [127:0] rd;
        int           ndone;
        int           k;
        int           done_at [2];

        vecs.push_back('{1'b1, 32'h0000_0120, 4'b1111,
            128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000, 128'h0});
        vecs.push_back('{1'b0, 32'h0000_0120, 4'b0000, 128'h0,
            128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000});
        vecs.push_back('{1'b1, 32'h0000_0120, 4'b0100,
            128'hFFFFFFFF_12345678_EEEEEEEE_99999999, 128'h0});
        vecs.push_back('{1'b0, 32'h0000_0120, 4'b0000, 128'h0,
            128'hDDDD0003_12345678_BBBB0001_AAAA0000});
        vecs.push_back('{1'b1, 32'h0000_004C, 4'b1111,
            128'h11111111_22222222_33333333_44444444, 128'h0});
        vecs.push_back('{1'b0, 32'hFFFF_C040, 4'b0000, 128'h0,
            128'h11111111_22222222_33333333_44444444});
        vecs.push_back('{1'b1, 32'h0000_0120, 4'b0000, 128'h0, 128'h0});
        vecs.push_back('{1'b0, 32'h0000_012C, 4'b0000, 128'h0,
            128'hDDDD0003_12345678_BBBB0001_AAAA0000});
        vecs.push_back('{1'b1, 32'h0000_0050, 4'b1111,
            128'h55555555_55555555_55555555_55555555, 128'h0});
        vecs.push_back('{1'b0, 32'h0000_0050, 4'b0000, 128'h0,
            128'h55555555_55555555_55555555_55555555});
        vecs.push_back('{1'b1, 32'h0000_3FF0, 4'b1111,
            128'h0F0F0F0F_1E1E1E1E_2D2D2D2D_3C3C3C3C, 128'h0});
        vecs.push_back('{1'b1, 32'h0000_3FF8, 4'b1001,
            128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3, 128'h0});
        vecs.push_back('{1'b0, 32'h0000_3FF4, 4'b0000, 128'h0,
            128'hA0A0A0A0_1E1E1E1E_2D2D2D2D_D3D3D3D3});

        // Power-on reset held from time 0, inspected mid-cycle.
        #23;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("idle_no_done", ndone, 0);
        chk("idle_ready", ready, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wmask,
                   vecs[i].wdata, rd);
            if (vecs[i].we) begin
                chk("rdata_hold_on_write", rd, last_rd);
            end else begin
                chk("rdata_read", rd, vecs[i].exp);
                last_rd = vecs[i].exp;
            end
        end

        // req held high with a changing bus while busy.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h0000_00A0; wmask = 4'hF;
        wdata = 128'h0000000A_1000000A_2000000A_3000000A;
        @(posedge clk);
        #1;
        addr  = 32'h0000_00B0;
        wdata = 128'h0000000B_1000000B_2000000B_3000000B;
        ndone = 0;
        done_at[0] = 0;
        done_at[1] = 0;
        for (k = 1; k <= 2 * (LATENCY + 2); k++) begin
            @(negedge clk);
            if (done) begin
                if (ndone < 2) done_at[ndone] = k;
                ndone++;
            end
            if (k == LATENCY + 2) chk("ready_after_first", ready, 1);
            if (k == LATENCY + 1) chk("ready_in_first_resp", ready, 0);
            if (k == 2 * (LATENCY + 2)) req = 1'b0;
        end
        chk("busy_done_count", ndone, 2);
        chk("busy_done1_at", done_at[0], LATENCY + 1);
        chk("busy_done2_at", done_at[1], 2 * LATENCY + 3);
        repeat (LATENCY + 2) @(negedge clk);
        chk("busy_quiet_ready", ready, 1);
        access(1'b0, 32'h0000_00A0, 4'h0, 128'h0, rd);
        chk("busy_captured_addr", rd,
            128'h0000000A_1000000A_2000000A_3000000A);
        access(1'b0, 32'h0000_00B0, 4'h0, 128'h0, rd);
        chk("busy_second_accept", rd,
            128'h0000000B_1000000B_2000000B_3000000B);
        last_rd = rd;

        // Mid-cycle reset while idle clears rdata.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_rdata", rdata, 128'h0);
        chk("midrst_ready", ready, 1);
        @(negedge clk);
        rst = 1'b0;
        last_rd = '0;

        // Reset during BUSY drops the pending write.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h0000_0050; wmask = 4'hF;
        wdata = 128'h66666666_66666666_66666666_66666666;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_done_low", done, 0);
        chk("abort_ready", ready, 1);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        access(1'b0, 32'h0000_0050, 4'h0, 128'h0, rd);
        chk("abort_old_data", rd,
            128'h55555555_55555555_55555555_55555555);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_line_server.md
Name: dmem_line_server

Overview:
- Main-memory responder on the far side of the data-cache refill/write-back interface.
- Serves 128-bit line reads (refills) and line write-backs issued by the cache controller.
- Supports a per-word write mask for partial writes.
- Models a fixed access latency with a counter-driven FSM and a single-outstanding-request handshake.

Parameters:
- LINE_AW, 10, log2 of number of 128-bit lines stored (1024 lines = 16 KB).
- LATENCY, 4, cycles from request acceptance to done; legal range 1..15.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  1  request valid from cache controller.
- we  input  1  1 = write-back/write, 0 = line read (refill); sampled with req.
- addr  input  32  byte address; bits [3:0] ignored (line aligned); line index = addr[LINE_AW+3:4]; higher bits ignored (aliasing).
- wmask  input  4  per-32-bit-word write enable; bit i covers wdata[32i+31:32i]; ignored for reads.
- wdata  input  128  write line, word 0 in [31:0].
- ready  output  1  responder idle and able to accept; handshake fires on req & ready.
- done  output  1  one-cycle pulse: access complete; for reads rdata is valid this cycle.
- rdata  output  128  read line; holds last read value until the next read completes.

Behaviour:
- Reset (async): state IDLE, ready=1 after the first edge-free reset release, done=0, rdata=0, latency counter=0, captured request registers cleared. Storage contents are not cleared.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - ready=1.
  - On req & ready: capture addr index, we, wmask, wdata; load counter with LATENCY-1; go to BUSY.
  - req while not ready is ignored (no queueing).
- BUSY:
  - ready=0.
  - Counter decrements each cycle.
  - When the counter equals 0:
    - Write: commits wdata words where wmask=1 into the indexed line; unmasked words are unchanged.
    - Read: loads rdata from the indexed line.
    - Go to RESP.
- RESP:
  - done=1 for exactly one cycle; ready=0.
  - Next state IDLE.
- Latency: req accepted at edge N, done high in the cycle after edge N+LATENCY, ready high again the following cycle. Minimum request-to-request spacing is LATENCY+2 cycles.
- Requests use captured values only; changes to addr/wdata/we after acceptance have no effect.
- Read of a line being written: impossible, single outstanding request.
- A write with wmask=0000 completes normally with done and changes no storage.
- Reset during BUSY aborts the access:
  - A write not yet committed (counter not yet 0) is lost.
  - No done pulse is produced.
- Reset during RESP clears done immediately.
- Reads return whatever is stored. Unwritten lines are undefined in RTL; the bench treats them as X.
- rdata changes only at read commit and at reset.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE, BUSY, RESP};
  - LINE_BITS=128, WORD_BITS=32, WORDS_PER_LINE=4, OFFSET_BITS=4;
  - counter width constant (4 bits).
- Sub-module dmem_line_array:
  - LINE_AW-addressed storage, 4 lanes of 32 bits;
  - synchronous masked write, synchronous read enable; no reset.
- The FSM, counter and capture registers stay in dmem_line_server.

Test Plan:
- Reset then idle:
  - Stimulus: assert rst mid-cycle, release.
  - Required: ready=1, done=0, rdata=0; no done pulse with req=0 for 20 cycles.
- Write then read, LATENCY=4:
  - Stimulus: write addr=0x0000_0120, wmask=1111, wdata=0xDDDD0003_CCCC0002_BBBB0001_AAAA0000 accepted at edge 0; then read addr=0x0000_0120.
  - Required: done at edge 5; read done 5 cycles after its accept, with rdata equal to the written line; ready low between accept and done+1.
- Partial write:
  - Stimulus: after the above, write wmask=0100, wdata word2=0x12345678, then read.
  - Required: rdata=0xDDDD0003_12345678_BBBB0001_AAAA0000.
- Aliasing and offset:
  - Stimulus: write line via addr=0x0000_004C, read via addr=0xFFFF_C040 (same index, LINE_AW=10).
  - Required: identical data returned.
- Ignored req while busy:
  - Stimulus: hold req=1 with changing addr/wdata during BUSY.
  - Required: exactly one done per acceptance; the original captured address is written; the next acceptance occurs only in the cycle after done.
- Reset mid-write:
  - Stimulus: accept a write to index 5 with new data, assert rst at BUSY cycle 2, then read index 5.
  - Required: no done for the aborted write; the read returns the old contents of index 5.
